// File: rtl/rr_record_packer.sv
// Two-stage record packer: S1 registers a logging unit, S2 holds the compacted record.
// Valid logb payloads are packed toward the LSB behind the logb/loge valid bitmaps.
package rr_record_packer_pkg;

    function automatic int unsigned field_at(input logic [1023:0] vals,
                                             input int unsigned idx,
                                             input int unsigned bits);
        logic [1023:0] shifted;
        int unsigned   result;
        shifted = vals >> (idx * bits);
        result  = 0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (b < bits) result[b] = shifted[b];
        end
        return result;
    endfunction

    function automatic int unsigned field_sum(input logic [1023:0] vals,
                                              input int unsigned cnt,
                                              input int unsigned bits);
        int unsigned total;
        total = 0;
        for (int unsigned i = 0; i < cnt; i++) begin
            total += field_at(vals, i, bits);
        end
        return total;
    endfunction

endpackage

module rr_record_packer
    import rr_record_packer_pkg::*;
#(
    parameter int unsigned LOGB_CHANNEL_CNT      = 4,
    parameter int unsigned LOGE_CHANNEL_CNT      = 4,
    parameter int unsigned RR_CHANNEL_WIDTH_BITS = 8,
    parameter logic [LOGB_CHANNEL_CNT*RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
        {8'd64, 8'd32, 8'd16, 8'd8},
    localparam int unsigned DATA_WIDTH =
        field_sum(1024'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT, RR_CHANNEL_WIDTH_BITS),
    localparam int unsigned FULL_WIDTH   = DATA_WIDTH + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
    localparam int unsigned OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
    input  logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid,
    input  logic [DATA_WIDTH-1:0]       in_logb_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [FULL_WIDTH-1:0]       out_data,
    output logic [OFFSET_WIDTH-1:0]     out_len,
    output logic [63:0]                 pkt_cnt,
    output logic [31:0]                 drop_cnt
);

    function automatic int unsigned chan_width(input int unsigned i);
        return field_at(1024'(CHANNEL_WIDTHS), i, RR_CHANNEL_WIDTH_BITS);
    endfunction

    function automatic int unsigned chan_base(input int unsigned i);
        return field_sum(1024'(CHANNEL_WIDTHS), i, RR_CHANNEL_WIDTH_BITS);
    endfunction

    function automatic logic [FULL_WIDTH-1:0] chan_mask(input int unsigned i);
        logic [FULL_WIDTH-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < FULL_WIDTH; b++) begin
            if (b < chan_width(i)) m[b] = 1'b1;
        end
        return m;
    endfunction

    logic                        running;
    logic                        s1_v;
    logic [LOGB_CHANNEL_CNT-1:0] s1_logb;
    logic [LOGE_CHANNEL_CNT-1:0] s1_loge;
    logic [DATA_WIDTH-1:0]       s1_data;

    logic                        s2_adv;
    logic                        s1_adv;
    logic                        s1_empty;
    logic [FULL_WIDTH-1:0]       ext_data;
    logic [FULL_WIDTH-1:0]       chunk;
    logic [FULL_WIDTH-1:0]       packed_data;
    logic [OFFSET_WIDTH-1:0]     packed_len;
    logic [OFFSET_WIDTH-1:0]     offset;

    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_v || s2_adv;
        // running holds in_ready low until the first clock edge after reset release
        in_ready = running && s1_adv;
        s1_empty = (s1_logb == '0) && (s1_loge == '0);
    end

    always_comb begin
        ext_data    = FULL_WIDTH'(s1_data);
        chunk       = '0;
        packed_data = '0;
        packed_data[LOGB_CHANNEL_CNT-1:0]                 = s1_logb;
        packed_data[LOGB_CHANNEL_CNT +: LOGE_CHANNEL_CNT] = s1_loge;
        offset      = OFFSET_WIDTH'(LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT);
        for (int unsigned i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            if (s1_logb[i]) begin
                chunk       = (ext_data >> chan_base(i)) & chan_mask(i);
                packed_data = packed_data | (chunk << offset);
                offset      = offset + OFFSET_WIDTH'(chan_width(i));
            end
        end
        packed_len = offset;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running   <= 1'b0;
            s1_v      <= 1'b0;
            s1_logb   <= '0;
            s1_loge   <= '0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            pkt_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            running <= 1'b1;

            if (in_ready) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_logb <= in_logb_valid;
                    s1_loge <= in_loge_valid;
                    s1_data <= in_logb_data;
                end
            end

            // Empty units retire from S1 here and never reach the output register
            if (s2_adv) begin
                out_valid <= s1_v && !s1_empty;
                if (s1_v && !s1_empty) begin
                    out_data <= packed_data;
                    out_len  <= packed_len;
                end
            end

            if (s1_v && s2_adv && s1_empty) drop_cnt <= drop_cnt + 32'd1;
            if (out_valid && out_ready)     pkt_cnt  <= pkt_cnt + 64'd1;
        end
    end

endmodule

// File: tb/tb_rr_record_packer.sv
// Bench for rr_record_packer: table vectors, corner-case sequences and a random
// stream checked against a bit-queue reference model and scoreboard.
module tb_rr_record_packer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_logb_valid;
    logic [3:0]   in_loge_valid;
    logic [119:0] in_logb_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [7:0]   out_len;
    logic [63:0]  pkt_cnt;
    logic [31:0]  drop_cnt;

    rr_record_packer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_logb_valid(in_logb_valid),
        .in_loge_valid(in_loge_valid),
        .in_logb_data (in_logb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_len      (out_len),
        .pkt_cnt      (pkt_cnt),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   len;
    } rec_t;

    typedef struct {
        logic [3:0]   lb;
        logic [3:0]   le;
        logic [119:0] d;
        logic [127:0] ed;
        logic [7:0]   el;
    } vec_t;

    rec_t sb[$];
    vec_t tv[7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int emit_cyc = -100;
    int emitted = 0;
    int exp_drops = 0;

    logic         s_in_ready;
    logic         s_out_valid;
    logic         acc;
    logic         emit;
    logic         prev_stall = 1'b0;
    logic [127:0] held_data;
    logic [7:0]   held_len;
    logic [127:0] last_data;
    logic [7:0]   last_len;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: stream bitmaps then each selected payload into a bit queue
    function automatic rec_t model_pack(input logic [3:0] lb, input logic [3:0] le,
                                        input logic [119:0] d);
        int   widths[4] = '{8, 16, 32, 64};
        bit   q[$];
        int   base = 0;
        rec_t r;
        for (int i = 0; i < 4; i++) q.push_back(lb[i]);
        for (int i = 0; i < 4; i++) q.push_back(le[i]);
        for (int ch = 0; ch < 4; ch++) begin
            if (lb[ch]) for (int b = 0; b < widths[ch]; b++) q.push_back(d[base + b]);
            base += widths[ch];
        end
        r.data = '0;
        for (int i = 0; i < q.size(); i++) r.data[i] = q[i];
        r.len = 8'(q.size());
        return r;
    endfunction

    task automatic step();
        rec_t r;
        @(negedge clk);
        cyc++;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held_data);
            check("stall_len", out_len, held_len);
        end
        prev_stall = out_valid && !out_ready;
        held_data  = out_data;
        held_len   = out_len;
        if (emit) begin
            emitted++;
            emit_cyc  = cyc;
            last_data = out_data;
            last_len  = out_len;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_emit: got data %h len %0d expected no output", out_data, out_len);
            end else begin
                r = sb.pop_front();
                check("emit_data", out_data, r.data);
                check("emit_len", out_len, r.len);
            end
        end
        if (acc) begin
            acc_cyc = cyc;
            if (in_logb_valid == 4'h0 && in_loge_valid == 4'h0) exp_drops++;
            else sb.push_back(model_pack(in_logb_valid, in_loge_valid, in_logb_data));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gen_unit();
        in_logb_data = 120'({$urandom, $urandom, $urandom, $urandom});
        if ($urandom_range(0, 7) == 0) begin
            in_logb_valid = 4'h0;
            in_loge_valid = 4'h0;
        end else begin
            in_logb_valid = 4'($urandom_range(0, 15));
            in_loge_valid = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
        check("drain_empty", sb.size(), 0);
        check("pkt_cnt_total", pkt_cnt, emitted);
        check("drop_cnt_total", drop_cnt, exp_drops);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_len"}, out_len, 0);
        check({tag, "_pkt_cnt"}, pkt_cnt, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    task automatic release_reset(input string tag);
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_ready_before_edge"}, in_ready, 0);
        @(posedge clk);
        #1;
        check({tag, "_ready_after_edge"}, in_ready, 1);
    endtask

    logic [119:0] dpat;
    logic [3:0]   lb_b;
    logic [3:0]   le_b;
    logic [119:0] d_b;
    int           n_acc;
    int           drops5;
    int           e0;
    int           e4;
    int           was_empty;

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_logb_valid = 4'h0;
        in_loge_valid = 4'h0;
        in_logb_data  = '0;
        out_ready     = 1'b1;
        dpat = {64'h0123456789ABCDEF, 32'hDEADBEEF, 16'h1234, 8'hAB};

        tv[0] = '{4'b0101, 4'b0010, dpat, {80'h0, 32'hDEADBEEF, 8'hAB, 4'h2, 4'h5}, 8'd48};
        tv[1] = '{4'b1111, 4'b0000, dpat, {dpat, 4'h0, 4'hF}, 8'd128};
        tv[2] = '{4'b0000, 4'b1000, dpat, 128'h80, 8'd8};
        tv[3] = '{4'b1000, 4'b0001, dpat, {56'h0, 64'h0123456789ABCDEF, 4'h1, 4'h8}, 8'd72};
        tv[4] = '{4'b0010, 4'b0000, dpat, {104'h0, 16'h1234, 4'h0, 4'h2}, 8'd24};
        tv[5] = '{4'b1010, 4'b1111, dpat, {40'h0, 64'h0123456789ABCDEF, 16'h1234, 4'hF, 4'hA}, 8'd88};
        tv[6] = '{4'b0001, 4'b0000, dpat, {112'h0, 8'hAB, 4'h0, 4'h1}, 8'd16};

        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        release_reset("por");

        // Table vectors: one unit at a time, exact 2-cycle latency
        foreach (tv[i]) begin
            in_valid      = 1'b1;
            in_logb_valid = tv[i].lb;
            in_loge_valid = tv[i].le;
            in_logb_data  = tv[i].d;
            step();
            check($sformatf("tbl%0d_accept", i), acc, 1);
            in_valid = 1'b0;
            repeat (3) step();
            check($sformatf("tbl%0d_latency", i), emit_cyc - acc_cyc, 2);
            check($sformatf("tbl%0d_data", i), last_data, tv[i].ed);
            check($sformatf("tbl%0d_len", i), last_len, tv[i].el);
        end
        drain(2);

        // Reset with two units in flight
        in_valid = 1'b1;
        gen_unit();
        in_logb_valid = 4'b0001;
        step();
        gen_unit();
        in_logb_valid = 4'b0100;
        step();
        in_valid = 1'b0;
        check("mid_inflight_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        reset_checks("mid");
        sb.delete();
        prev_stall = 1'b0;
        emitted    = 0;
        exp_drops  = 0;
        repeat (2) @(posedge clk);
        #1;
        release_reset("mid");
        in_valid      = 1'b1;
        in_logb_valid = 4'b0011;
        in_loge_valid = 4'b0110;
        in_logb_data  = dpat;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("mid_post_latency", emit_cyc - acc_cyc, 2);
        check("mid_post_emitted", emitted, 1);
        check("mid_post_data", last_data, {72'h0, 16'h1234, 8'hAB, 4'h6, 4'h3});
        check("mid_post_len", last_len, 8'd32);
        drain(1);

        // Empty unit sandwiched between two valid units
        e4 = emitted;
        lb_b = 4'b1001;
        le_b = 4'b0100;
        d_b  = 120'({$urandom, $urandom, $urandom, $urandom});
        in_valid      = 1'b1;
        in_logb_valid = 4'b0100;
        in_loge_valid = 4'b0000;
        in_logb_data  = dpat;
        step();
        in_logb_valid = 4'h0;
        in_loge_valid = 4'h0;
        step();
        in_logb_valid = lb_b;
        in_loge_valid = le_b;
        in_logb_data  = d_b;
        step();
        drain(4);
        check("empty_pkt_delta", emitted - e4, 2);
        check("empty_drop_cnt", drop_cnt, 1);
        check("empty_last_data", last_data, {40'h0, d_b[119:56], d_b[7:0], le_b, lb_b});

        // Backpressure: stall 10 cycles with input offered, then release
        in_valid  = 1'b1;
        out_ready = 1'b0;
        gen_unit();
        n_acc = 0;
        repeat (10) begin
            step();
            if (acc) begin
                n_acc++;
                gen_unit();
            end
        end
        check("bp_accepted", n_acc, 2);
        check("bp_in_ready_low", s_in_ready, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("bp_stream_valid%0d", k), s_out_valid, 1);
            check($sformatf("bp_stream_ready%0d", k), s_in_ready, 1);
            if (acc) gen_unit();
        end
        drain(4);

        // Random stream with random backpressure
        e0     = emitted;
        n_acc  = 0;
        drops5 = 0;
        in_valid = 1'b1;
        gen_unit();
        for (int c = 0; c < 3000 && n_acc < 100; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            was_empty = (in_logb_valid == 4'h0 && in_loge_valid == 4'h0) ? 1 : 0;
            step();
            if (acc) begin
                n_acc++;
                drops5 += was_empty;
                gen_unit();
            end
        end
        if (n_acc < 100) begin
            checks++;
            errors++;
            $display("FAIL rand_accept_timeout: got %0d units accepted expected 100", n_acc);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 500 && sb.size() != 0; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain(3);
        check("rand_pkt_cnt", pkt_cnt, 64'(e0 + 100 - drops5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
